vnu_t2s_sat: RTL and testbench

Streaming two's-complement to sign-magnitude converter with magnitude saturation. It sits at the VNU output and performs the reverse of the S_to_T input conversion. The VNU's wide two's-complement sums are clamped and repacked into the DATA_WIDTH sign-magnitude format consumed by the CNU. The block is a 2-stage valid/ready pipeline with full throughput and backpressure, and it keeps a saturation-event counter for debug.

---
 rtl/vnu_t2s_sat_if.sv | 25 ++
 rtl/vnu_t2s_sat.sv | 104 ++++++++++
 tb/tb_vnu_t2s_sat.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vnu_t2s_sat_if.sv
// Stream bundle between the VNU sum output, the converter and the CNU input.
// master: the side that feeds sums in and drains results (VNU/CNU harness).
// slave:  the converter itself.
interface vnu_t2s_sat_if #(
    parameter int DATA_WIDTH = 6,
    parameter int SUM_WIDTH  = 9
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SUM_WIDTH-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/vnu_t2s_sat.sv
// Two's-complement to sign-magnitude converter with magnitude clamp.
// S1 splits the wide sum into sign and unsigned magnitude, S2 clamps the
// magnitude to the narrow format and suppresses negative zero. Both stages
// are skid-free valid/ready registers; sat_count tallies clamped results
// that actually leave the block.
module vnu_t2s_sat #(
    parameter int DATA_WIDTH = 6,
    parameter int SUM_WIDTH  = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    vnu_t2s_sat_if.slave         bus,
    input  logic                 sat_clr,
    output logic [CNT_WIDTH-1:0] sat_count
);
    localparam int                    MAXM_INT = (1 << (DATA_WIDTH - 1)) - 1;
    localparam logic [SUM_WIDTH-1:0]  MAXM     = SUM_WIDTH'(MAXM_INT);
    localparam logic [DATA_WIDTH-2:0] MAXM_OUT = (DATA_WIDTH - 1)'(MAXM_INT);

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q,  s1_sign_d;
    logic [SUM_WIDTH-1:0]  s1_mag_q,   s1_mag_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;
    logic                  s2_sat_q,   s2_sat_d;
    logic [CNT_WIDTH-1:0]  sat_count_q, sat_count_d;

    logic                  s1_en;
    logic                  s2_en;
    logic                  sat_hit;
    logic [DATA_WIDTH-2:0] mag_out;

    // Stage enables; in_ready is held low during reset so nothing is taken in.
    always_comb begin
        s2_en = !s2_valid_q || bus.out_ready;
        s1_en = !s1_valid_q || s2_en;
    end

    // S1: sign split and unsigned absolute value (the most negative sum
    // yields 2^(SUM_WIDTH-1), which is still correct read as unsigned).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            s1_sign_d  = bus.in_data[SUM_WIDTH-1];
            s1_mag_d   = bus.in_data[SUM_WIDTH-1] ? (~bus.in_data + SUM_WIDTH'(1))
                                                  : bus.in_data;
        end
    end

    // S2: clamp to MAXM and pack; a zero magnitude always carries a + sign.
    always_comb begin
        sat_hit    = s1_mag_q > MAXM;
        mag_out    = sat_hit ? MAXM_OUT : s1_mag_q[DATA_WIDTH-2:0];
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = {s1_sign_q && (mag_out != '0), mag_out};
            s2_sat_d   = sat_hit;
        end
    end

    // Debug counter: clear wins over a same-cycle saturated handshake; sticks at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (s2_valid_q && bus.out_ready && s2_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign bus.in_ready  = s1_en && !rst;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_sat   = s2_sat_q;
    assign sat_count     = sat_count_q;
endmodule

// File: tb/tb_vnu_t2s_sat.sv
// Bench for vnu_t2s_sat: directed vectors, an arithmetic reference model and
// an in-order scoreboard. A second instance with a 4-bit counter covers the
// sticky/clear behaviour of sat_count.
module tb_vnu_t2s_sat;
    localparam int DW = 6;
    localparam int SW = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        sat_clr;
    logic        sat_clr2;
    logic [15:0] sat_count;
    logic [3:0]  sat_count2;

    vnu_t2s_sat_if #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) bus ();
    vnu_t2s_sat_if #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) bus2 ();

    vnu_t2s_sat #(.DATA_WIDTH(DW), .SUM_WIDTH(SW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    vnu_t2s_sat #(.DATA_WIDTH(DW), .SUM_WIDTH(SW), .CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .sat_clr(sat_clr2), .sat_count(sat_count2)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    bit         mon_en   = 1'b0;
    logic [6:0] exp_q[$];     // {sat, data} in acceptance order
    logic [8:0] tx_q[$];      // words still to be sent
    int         exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the signed value.
    function automatic logic [6:0] model(input logic [8:0] x);
        int   v;
        int   a;
        logic s;
        v = $signed(x);
        s = (v < 0);
        a = s ? -v : v;
        if (a > 31) return {1'b1, s, 5'd31};
        return {1'b0, (a != 0) ? s : 1'b0, a[4:0]};
    endfunction

    // Scoreboard and counter model, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin : cmp
        logic hs_sat;
        #1;
        if (mon_en) begin
            hs_sat = 1'b0;
            chk("sat_count", sat_count, exp_cnt);
            if (rst) begin
                chk("in_ready_in_reset", bus.in_ready, 0);
                exp_q.delete();
                exp_cnt = 0;
            end else begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_when_empty", bus.out_valid, 0);
                end else if (bus.out_valid) begin
                    chk("out_data", bus.out_data, exp_q[0][5:0]);
                    chk("out_sat", bus.out_sat, exp_q[0][6]);
                    if (bus.out_ready) begin
                        hs_sat = exp_q[0][6];
                        void'(exp_q.pop_front());
                    end
                end
                if (sat_clr) exp_cnt = 0;
                else if (hs_sat && exp_cnt < 65535) exp_cnt++;
                if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_data));
            end
        end
    end

    // Streams tx_q with valid/ready probabilities (percent); valid is held until accepted.
    task automatic run_stream(input int pv, input int pr, input int bound);
        int cyc  = 0;
        bit held = 1'b0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && cyc < bound) begin
            @(negedge clk);
            if (!held) begin
                bus.in_valid = (tx_q.size() > 0) && ($urandom_range(0, 99) < pv);
                bus.in_data  = bus.in_valid ? tx_q[0] : 9'($urandom_range(0, 511));
            end
            bus.out_ready = ($urandom_range(0, 99) < pr);
            #2;
            held = bus.in_valid && !bus.in_ready;
            if (bus.in_valid && bus.in_ready) void'(tx_q.pop_front());
            cyc++;
        end
        chk("stream_drained", tx_q.size() + exp_q.size(), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Sends one word into an empty pipe and checks the result against literals.
    task automatic lit_word(input logic [8:0] v, input logic [5:0] ed, input logic es,
                            input string nm);
        int k = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = v;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        while (!bus.out_valid && k < 5) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_data"}, bus.out_data, ed);
        chk({nm, "_sat"}, bus.out_sat, es);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int         first_acc;
        int         first_ov;
        int         last_ov;
        int         ov_cnt;
        int         acc;
        logic [5:0] held_data;

        rst           = 1'b1;
        sat_clr       = 1'b0;
        sat_clr2      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        #2;
        chk("in_ready_during_rst", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        mon_en = 1'b1;

        // Hand-computed corner values.
        lit_word(9'h000, 6'b000000, 1'b0, "zero");
        lit_word(9'h005, 6'b000101, 1'b0, "plus5");
        lit_word(9'h1FF, 6'b100001, 1'b0, "minus1");
        lit_word(9'h1E1, 6'b111111, 1'b0, "minus31");
        lit_word(9'h1E0, 6'b111111, 1'b1, "minus32");
        lit_word(9'h028, 6'b011111, 1'b1, "plus40");
        lit_word(9'h100, 6'b111111, 1'b1, "minus256");
        #2;
        chk("lit_sat_count", sat_count, 3);

        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;

        // Exhaustive sweep at full rate.
        for (int i = 0; i < 512; i++) tx_q.push_back(9'(i));
        run_stream(100, 100, 2000);
        #2;
        chk("sweep_sat_count", sat_count, 449);

        // Latency and throughput: 8 back-to-back words.
        for (int i = 0; i < 8; i++) tx_q.push_back(9'(i * 37 + 3));
        first_acc = -1;
        first_ov  = -1;
        last_ov   = -1;
        ov_cnt    = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus.in_valid  = (tx_q.size() > 0);
            if (tx_q.size() > 0) bus.in_data = tx_q[0];
            bus.out_ready = 1'b1;
            #2;
            if (bus.out_valid) begin
                if (first_ov < 0) first_ov = c;
                last_ov = c;
                ov_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (first_acc < 0) first_acc = c;
                void'(tx_q.pop_front());
            end
        end
        chk("latency", first_ov - first_acc, 2);
        chk("burst_valid_count", ov_cnt, 8);
        chk("burst_contiguous", last_ov - first_ov, 7);

        // Backpressure: out_ready low for 5 cycles while streaming.
        for (int i = 0; i < 6; i++) tx_q.push_back(9'(200 - i * 61));
        acc       = 0;
        held_data = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_data   = tx_q[0];
            bus.out_ready = 1'b0;
            #2;
            if (c >= 2) chk("bp_in_ready_low", bus.in_ready, 0);
            if (c == 2) held_data = bus.out_data;
            if (c == 4) chk("bp_out_data_stable", bus.out_data, held_data);
            if (bus.in_valid && bus.in_ready) begin
                acc++;
                void'(tx_q.pop_front());
            end
        end
        chk("bp_accepted", acc, 2);
        run_stream(100, 100, 200);

        // Random valid/ready toggling.
        for (int i = 0; i < 10000; i++) tx_q.push_back(9'($urandom_range(0, 511)));
        run_stream(70, 60, 60000);

        // 4-bit counter: sticks at 15, clear beats a simultaneous saturated handshake.
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.in_data  = 9'h19C;
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("cnt4_stick", sat_count2, 15);
        bus2.out_ready = 1'b0;
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 9'h0C8;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("cnt4_pending_valid", bus2.out_valid, 1);
        chk("cnt4_pending_sat", bus2.out_sat, 1);
        chk("cnt4_still_15", sat_count2, 15);
        @(negedge clk);
        bus2.out_ready = 1'b1;
        sat_clr2       = 1'b1;
        @(negedge clk);
        sat_clr2 = 1'b0;
        #2;
        chk("cnt4_clr_priority", sat_count2, 0);
        chk("cnt4_drained", bus2.out_valid, 0);

        // Reset with two words in flight.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 9'h19C;
        @(negedge clk);
        bus.in_data   = 9'h064;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sat_count", sat_count, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #2;
            chk("midrst_no_stale", bus.out_valid, 0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
